// File: rtl/multi_cycle_controller_if.sv
// Control bundle between the multi-cycle controller and the CPU datapath.
// The controller is the master: it reads IR fields and the ALU zero flag and drives every datapath select/enable.
interface multi_cycle_controller_if #(parameter int ALU_W = 3);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             pc_en;
    logic             ir_write;
    logic             mem_write;
    logic             iord;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic [ALU_W-1:0] alu_control;
    logic             illegal_op;
    logic [3:0]       state;

    modport master (
        input  opcode, funct, zero,
        output pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, pc_src, alu_control, illegal_op, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, pc_src, alu_control, illegal_op, state
    );
endinterface

// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle CPU: sequences PC, IR, memory, register file and the shared ALU.
//
// state    | meaning
// FETCH    | read instr at PC into IR, PC <= PC+4
// DECODE   | dispatch on opcode, precompute branch target into ALUOut
// MEMADR   | ALUOut <= A + sign-extended imm (lw/sw)
// MEMREAD  | read memory at ALUOut into MDR
// MEMWB    | rt <= MDR
// MEMWRITE | memory[ALUOut] <= B
// EXECUTE  | R-type ALU operation selected by funct
// ALUWB    | rd <= ALUOut
// BRANCH   | compare A/B, load PC from ALUOut if equal
// ADDIEX   | ALUOut <= A + sign-extended imm
// ADDIWB   | rt <= ALUOut
// JUMP     | PC <= jump target
module multi_cycle_controller #(
    parameter int ALU_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    multi_cycle_controller_if.master     bus
);
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   funct_ok;

    logic             pc_en_c, ir_write_c, mem_write_c, iord_c, reg_write_c;
    logic             reg_dst_c, mem_to_reg_c, alu_src_a_c;
    logic [1:0]       alu_src_b_c, pc_src_c;
    logic [ALU_W-1:0] alu_control_c, funct_alu;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (bus.funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = FETCH;
        illegal_d = 1'b0;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    6'b100011, 6'b101011: state_d = MEMADR;
                    6'b000100:            state_d = BRANCH;
                    6'b001000:            state_d = ADDIEX;
                    6'b000010:            state_d = JUMP;
                    6'b000000: begin
                        if (funct_ok) state_d = EXECUTE;
                        else          illegal_d = 1'b1;
                    end
                    default:              illegal_d = 1'b1;
                endcase
            end
            // IR is only loaded in FETCH, so the opcode still tells lw from sw here
            MEMADR:  state_d = (bus.opcode == 6'b101011) ? MEMWRITE : MEMREAD;
            MEMREAD: state_d = MEMWB;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_en_c       = 1'b0;
        ir_write_c    = 1'b0;
        mem_write_c   = 1'b0;
        iord_c        = 1'b0;
        reg_write_c   = 1'b0;
        reg_dst_c     = 1'b0;
        mem_to_reg_c  = 1'b0;
        alu_src_a_c   = 1'b0;
        alu_src_b_c   = 2'b00;
        pc_src_c      = 2'b00;
        alu_control_c = ALU_ADD;
        case (state_q)
            FETCH: begin
                ir_write_c  = 1'b1;
                pc_en_c     = 1'b1;
                alu_src_b_c = 2'b01;
            end
            DECODE:  alu_src_b_c = 2'b11;
            MEMADR, ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
            end
            MEMREAD: iord_c = 1'b1;
            MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
            end
            MEMWRITE: begin
                iord_c      = 1'b1;
                mem_write_c = 1'b1;
            end
            EXECUTE: begin
                alu_src_a_c   = 1'b1;
                alu_control_c = funct_alu;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
            end
            ADDIWB:  reg_write_c = 1'b1;
            BRANCH: begin
                alu_src_a_c   = 1'b1;
                alu_control_c = ALU_SUB;
                pc_src_c      = 2'b01;
                pc_en_c       = bus.zero;
            end
            JUMP: begin
                pc_src_c = 2'b10;
                pc_en_c  = 1'b1;
            end
            default: ;
        endcase
    end

    // Architectural state must not change while reset is held, whatever state was current
    assign bus.pc_en       = pc_en_c     & ~rst;
    assign bus.ir_write    = ir_write_c  & ~rst;
    assign bus.mem_write   = mem_write_c & ~rst;
    assign bus.reg_write   = reg_write_c & ~rst;
    assign bus.iord        = iord_c;
    assign bus.reg_dst     = reg_dst_c;
    assign bus.mem_to_reg  = mem_to_reg_c;
    assign bus.alu_src_a   = alu_src_a_c;
    assign bus.alu_src_b   = alu_src_b_c;
    assign bus.pc_src      = pc_src_c;
    assign bus.alu_control = alu_control_c;
    assign bus.illegal_op  = illegal_q;
    assign bus.state       = state_q;
endmodule
